vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Frame-buffer access controller sitting between a single-port 8-bit pixel memory and `vga_driver`. Tracks the scan position on a pixel-clock strobe, prefetches the next displayed pixel from memory, and drives `pixel_color` into the driver. Grants a write-only requester (game/drawing logic) access to the same memory port in every cycle not used for display fetches. Stores a down-scaled frame buffer (160x120 by default), each entry replicated over a 2^SCALE x 2^SCALE screen block.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_TOTAL`, 800, pixel ticks per line including blanking
- `V_ACTIVE`, 480, visible lines per frame
- `V_TOTAL`, 525, lines per frame including blanking
- `SCALE`, 2, log2 of screen pixels per frame-buffer pixel per axis
- `FB_W`, 160, frame-buffer width in entries (H_ACTIVE >> SCALE)
- `ADDR_W`, 15, memory address width
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high
- `pix_tick`  in  1  one-cycle strobe per displayed pixel, minimum spacing 3 cycles
- `frame_sync`  in  1  one-cycle pulse; forces scan position to (0,0)
- `wr_req`  in  1  writer request; held until `wr_gnt`
- `wr_addr`  in  ADDR_W  writer address
- `wr_data`  in  8  writer data
- `wr_gnt`  out  1  write performed this cycle
- `mem_addr`  out  ADDR_W  memory address
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  8  memory write data
- `mem_rdata`  in  8  memory read data, valid the cycle after the address (registered read)
- `pixel_color`  out  8  pixel to `vga_driver`
- `in_active`  out  1  `pixel_color` belongs to the visible area

## Operation
- Scan position P = (h, v): next pixel to be shown. `fetch_q` (8 b) holds color for P. active(P) = h < H_ACTIVE and v < V_ACTIVE.
- addr(P) = (v >> SCALE) * FB_W + (h >> SCALE), truncated to ADDR_W.
- FSM states: IDLE, RD, RDW.
  - RD: `mem_addr` = addr(P), `mem_we` = 0; next RDW.
  - RDW: `fetch_q` <= `mem_rdata`; next IDLE.
  - IDLE: port free for writer.
- On `pix_tick` (any state): `pixel_color` <= active(P) ? `fetch_q` : 8'h00; `in_active` <= active(P); P <= P+1 (h wraps at H_TOTAL-1 to 0 with v+1; v wraps at V_TOTAL-1 to 0); next state RD if active(P+1), else IDLE. Tick in RD/RDW aborts the fetch and restarts it for the new P.
- `frame_sync`: P <= (0,0), state <= RD. Wins over a simultaneous `pix_tick` counter update; `pixel_color` <= 0, `in_active` <= 0 in that cycle.
- Writer: in IDLE with `wr_req` = 1: `mem_we` = 1, `mem_addr` = `wr_addr`, `mem_wdata` = `wr_data`, `wr_gnt` = 1 (combinational, same cycle). A write may coincide with a `pix_tick` in IDLE. Never write in RD/RDW; `wr_gnt` = 0 there.
- `mem_wdata` = `wr_data` always; `mem_addr` = 0 in IDLE with no request.

## Timing
- Reset (while `reset` high and the cycle after): P = (0,0), `fetch_q` = 0, `pixel_color` = 0, `in_active` = 0, `wr_gnt` = 0, `mem_we` = 0, `mem_addr` = 0; state = RD on release, so addr 0 is fetched in the first two cycles after reset.
- Fetch latency: tick at cycle t → RD at t+1 → `fetch_q` valid at t+3 (before the next tick at ≥ t+3).
- `pixel_color` registered: updates the cycle after `pix_tick`.
- Write grant latency: 0 cycles in IDLE; at most 2 cycles when the request arrives in RD.
- Reset mid-frame: all state returns to reset values; a pending `wr_req` is not granted while `reset` is high.

## Test plan
- Memory addr 0 = 8'h3C; release reset, tick every 4 cycles → `mem_addr` = 0 in cycle 1 with `mem_we` = 0; after the first tick `pixel_color` = 8'h3C, `in_active` = 1.
- Scaling: ticks across h = 0..4 on v = 0 → reads addr 0 for h = 0..3 and addr 1 for h = 4; at v = 4, h = 0 → addr 160.
- Blanking: h = 640..799 → `pixel_color` = 8'h00, `in_active` = 0, FSM stays IDLE, no reads; a read of addr 0 is issued after tick at (799,524) wraps to (0,0).
- Arbitration: `wr_req` with addr 5/data 8'hAA asserted in the RD cycle → `wr_gnt` two cycles later with `mem_we` = 1, `mem_addr` = 5; `mem_we` never 1 in RD/RDW over a full frame of random requests.
- Write then display: write 8'h77 to addr 161, scan to (4,4) → `pixel_color` = 8'h77.
- `frame_sync` coincident with a tick at (300,200) → next fetch addr 0, `pixel_color` = 0; `reset` mid-line → outputs back to reset values the following cycle.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - writer request port and single-port pixel memory bus
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, mem_rdata,
        output wr_gnt, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_gnt, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer port shared between display prefetch and a write requester
module vga_fb_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int SCALE    = 2,
    parameter int FB_W     = 160,
    parameter int ADDR_W   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_tick,
    input  logic                  frame_sync,
    vga_fb_arbiter_if.slave       bus,
    output logic [7:0]            pixel_color,
    output logic                  in_active
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    typedef enum logic [1:0] {IDLE, RD, RDW} state_t;

    state_t            state;
    logic [HW-1:0]     h;
    logic [HW-1:0]     h_next;
    logic [VW-1:0]     v;
    logic [VW-1:0]     v_next;
    logic [7:0]        fetch_q;
    logic              act_cur;
    logic              act_next;
    logic [ADDR_W-1:0] fb_addr;
    logic              wr_ok;

    always_comb begin
        h_next = h + 1'b1;
        v_next = v;
        if (h == HW'(H_TOTAL - 1)) begin
            h_next = '0;
            v_next = (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end
    end

    assign act_cur  = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    assign act_next = (h_next < HW'(H_ACTIVE)) && (v_next < VW'(V_ACTIVE));
    assign fb_addr  = ADDR_W'(v >> SCALE) * ADDR_W'(FB_W) + ADDR_W'(h >> SCALE);

    // The writer only ever owns the port while no display fetch is in flight.
    assign wr_ok         = (state == IDLE) && bus.wr_req && !reset;
    assign bus.wr_gnt    = wr_ok;
    assign bus.mem_we    = wr_ok;
    assign bus.mem_wdata = bus.wr_data;

    always_comb begin
        bus.mem_addr = '0;
        if (!reset && state == RD)
            bus.mem_addr = fb_addr;
        else if (wr_ok)
            bus.mem_addr = bus.wr_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h           <= '0;
            v           <= '0;
            fetch_q     <= '0;
            pixel_color <= '0;
            in_active   <= 1'b0;
            state       <= RD;
        end else if (frame_sync) begin
            h           <= '0;
            v           <= '0;
            pixel_color <= '0;
            in_active   <= 1'b0;
            state       <= RD;
        end else if (pix_tick) begin
            // A tick mid-fetch abandons it; the new position is fetched instead.
            pixel_color <= act_cur ? fetch_q : 8'h00;
            in_active   <= act_cur;
            h           <= h_next;
            v           <= v_next;
            state       <= act_next ? RD : IDLE;
        end else begin
            case (state)
                RD:      state <= RDW;
                RDW: begin
                    fetch_q <= bus.mem_rdata;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - randomized bench for vga_fb_arbiter against a scan/fetch reference model
module tb_vga_fb_arbiter;
    localparam int HA = 32;
    localparam int HT = 40;
    localparam int VA = 16;
    localparam int VT = 20;
    localparam int SC = 2;
    localparam int FW = 8;
    localparam int AW = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_tick = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] pixel_color;
    logic       in_active;

    vga_fb_arbiter_if #(.ADDR_W(AW)) bus ();

    vga_fb_arbiter #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
        .SCALE(SC), .FB_W(FW), .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pix_tick(pix_tick),
        .frame_sync(frame_sync),
        .bus(bus),
        .pixel_color(pixel_color),
        .in_active(in_active)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:32767];
    logic [7:0] ref_mem [0:32767];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    int mh, mv, ph, exp_fetch, pfetch, exp_pix, exp_act;
    bit pend;
    int waddr, wdata, wr_rate;

    function automatic int maddr(input int h, input int v);
        return ((v >> SC) * FW + (h >> SC)) & ((1 << AW) - 1);
    endfunction

    function automatic bit is_act(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input bit tick, input bit fs, input bit rst);
        bit e_gnt;
        bit a;
        @(posedge clk);
        #1;
        reset      = rst;
        pix_tick   = tick;
        frame_sync = fs;
        if (!pend && wr_rate != 0 && $urandom_range(0, 99) < wr_rate) begin
            pend  = 1'b1;
            waddr = $urandom_range(0, 63);
            wdata = $urandom_range(0, 255);
        end
        bus.wr_req  = pend;
        bus.wr_addr = AW'(waddr);
        bus.wr_data = 8'(wdata);
        @(negedge clk);

        check_val("pixel_color", 32'(pixel_color), 32'(exp_pix));
        check_val("in_active", 32'(in_active), 32'(exp_act));
        check_val("mem_wdata", 32'(bus.mem_wdata), 32'(wdata & 255));
        e_gnt = 1'b0;
        if (rst) begin
            check_val("rst_gnt", 32'(bus.wr_gnt), 32'd0);
            check_val("rst_we", 32'(bus.mem_we), 32'd0);
            check_val("rst_addr", 32'(bus.mem_addr), 32'd0);
        end else if (ph == 1) begin
            check_val("rd_addr", 32'(bus.mem_addr), 32'(maddr(mh, mv)));
            check_val("rd_we", 32'(bus.mem_we), 32'd0);
            check_val("rd_gnt", 32'(bus.wr_gnt), 32'd0);
            pfetch = ref_mem[maddr(mh, mv)];
        end else if (ph == 2) begin
            check_val("rdw_we", 32'(bus.mem_we), 32'd0);
            check_val("rdw_gnt", 32'(bus.wr_gnt), 32'd0);
        end else begin
            e_gnt = pend;
            check_val("idle_gnt", 32'(bus.wr_gnt), 32'(e_gnt));
            check_val("idle_we", 32'(bus.mem_we), 32'(e_gnt));
            check_val("idle_addr", 32'(bus.mem_addr), e_gnt ? 32'(waddr) : 32'd0);
        end

        if (rst) begin
            mh = 0; mv = 0; exp_fetch = 0; exp_pix = 0; exp_act = 0; ph = 1;
        end else if (fs) begin
            mh = 0; mv = 0; exp_pix = 0; exp_act = 0; ph = 1;
        end else if (tick) begin
            a       = is_act(mh, mv);
            exp_pix = a ? exp_fetch : 0;
            exp_act = a;
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
            ph = is_act(mh, mv) ? 1 : 0;
        end else if (ph == 1) begin
            ph = 2;
        end else if (ph == 2) begin
            exp_fetch = pfetch;
            ph = 0;
        end
        if (e_gnt) begin
            ref_mem[waddr] = 8'(wdata);
            pend = 1'b0;
        end
    endtask

    task automatic tick_run(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < gap - 1; k++) step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 8'($urandom_range(0, 255));
            ref_mem[i] = mem[i];
        end
        mem[0] = 8'h3C;
        ref_mem[0] = 8'h3C;
        mh = 0; mv = 0; ph = 1; exp_fetch = 0; pfetch = 0; exp_pix = 0; exp_act = 0;
        pend = 1'b0; waddr = 0; wdata = 0; wr_rate = 0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // First fetch after reset, then first displayed pixel
        step(1'b0, 1'b0, 1'b0);
        check_val("first_fetch_addr", 32'(bus.mem_addr), 32'd0);
        check_val("first_fetch_we", 32'(bus.mem_we), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_val("first_pixel", 32'(pixel_color), 32'h3C);
        check_val("first_active", 32'(in_active), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Scaling: h = 2..4 on line 0 map to entries 0, 0, 1
        for (int i = 2; i <= 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            check_val("scale_addr", 32'(bus.mem_addr), 32'(i >> SC));
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end

        // Request arriving in the fetch cycle waits two cycles
        step(1'b0, 1'b1, 1'b0);
        pend = 1'b1; waddr = 5; wdata = 8'hAA;
        step(1'b0, 1'b0, 1'b0);
        check_val("arb_rd_gnt", 32'(bus.wr_gnt), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check_val("arb_rdw_gnt", 32'(bus.wr_gnt), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check_val("arb_gnt", 32'(bus.wr_gnt), 32'd1);
        check_val("arb_addr", 32'(bus.mem_addr), 32'd5);
        check_val("arb_we", 32'(bus.mem_we), 32'd1);

        // Write then display at screen (4,4)
        pend = 1'b1; waddr = FW + 1; wdata = 8'h77;
        step(1'b0, 1'b0, 1'b0);
        check_val("wr77_gnt", 32'(bus.wr_gnt), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        tick_run(4 * HT + 5, 4);
        step(1'b0, 1'b0, 1'b0);
        check_val("wr77_pixel", 32'(pixel_color), 32'h77);

        // Random writer traffic over more than two frames
        wr_rate = 30;
        for (int n = 0; n < 2000; n++) begin
            int gap;
            gap = $urandom_range(3, 5);
            for (int k = 0; k < gap - 1; k++) step(1'b0, 1'b0, 1'b0);
            step(1'b1, ($urandom_range(0, 399) == 0), 1'b0);
        end
        wr_rate = 0;

        // Frame sync coincident with a tick
        tick_run(3, 4);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_val("fs_pixel", 32'(pixel_color), 32'd0);
        check_val("fs_active", 32'(in_active), 32'd0);
        check_val("fs_addr", 32'(bus.mem_addr), 32'd0);

        // Reset in the middle of a line
        tick_run(6, 4);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check_val("rst_mid_pixel", 32'(pixel_color), 32'd0);
        check_val("rst_mid_active", 32'(in_active), 32'd0);
        check_val("rst_mid_addr", 32'(bus.mem_addr), 32'd0);
        check_val("rst_mid_we", 32'(bus.mem_we), 32'd0);
        tick_run(4, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
